spi_slave_rx: RTL and testbench

- Receive-side counterpart and downstream consumer of the 16-bit SPI master transmitter.
- Oversamples spi_cs / spi_sclk / spi_data in the system clk domain and deserializes MSB-first words.
- Buffers received words in a small first-word-fall-through FIFO exposed through a valid/ready interface to the SoC bus or loopback checker.
- Flags overruns and truncated frames.

---
 rtl/spi_slave_rx_if.sv | 12 +
 rtl/spi_slave_rx.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_rx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_rx_if.sv
// Receive-side word handshake between spi_slave_rx and its consumer.
// The master drives the FIFO head word and valid; the consumer drives ready.
interface spi_slave_rx_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_slave_rx.sv
// SPI receive slave: oversamples cs/sclk/data in clk, shifts MSB-first words
// into a first-word-fall-through FIFO, and flags overruns and truncated frames.
//
// state     | meaning
// WAIT_IDLE | after reset; wait for CS high so a frame in flight is never joined
// IDLE      | CS high; bit counter held at 0
// SHIFT     | CS low; capture one bit per sclk rising edge, push every DATA_W bits
module spi_slave_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_cs,
  input  logic                          spi_sclk,
  input  logic                          spi_data,
  spi_slave_rx_if.master                rx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sclk_d;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   data_s;
  logic                   rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      data_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;

  state_t              state;
  logic [DATA_W-2:0]   shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SET_W-1:0]    settle_cnt;
  logic                push_req;
  logic [DATA_W-1:0]   push_word;

  // The cs chain resets to 1, so cs_s reads high until real samples reach the
  // end of the chain; settle_cnt keeps WAIT_IDLE from trusting it before then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      settle_cnt <= SET_W'(SYNC_STAGES);
      push_req   <= 1'b0;
      push_word  <= '0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (settle_cnt != '0)
            settle_cnt <= settle_cnt - SET_W'(1);
          else if (cs_s)
            state <= IDLE;
        end
        IDLE: begin
          bit_cnt <= '0;
          if (!cs_s) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            if (bit_cnt != '0)
              frame_err <= 1'b1;
            bit_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (rise) begin
            shift_reg <= {shift_reg[DATA_W-3:0], data_s};
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              push_req  <= 1'b1;
              push_word <= {shift_reg, data_s};
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= WAIT_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;
  logic              full;
  logic              push_ok;

  assign pop     = rx.rx_valid & rx.rx_ready;
  assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign push_ok = push_req & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push_req & full & ~pop;
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign rx.rx_data  = mem[rd_ptr];
  assign rx.rx_valid = (fifo_level != '0);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives SPI frames with 4-clk sclk phases and checks
// popped words, levels and error pulses against a queue model of the spec.
module tb_spi_slave_rx;
  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_data;
  logic [2:0]  fifo_level;
  logic        overrun;
  logic        frame_err;
  logic        busy;

  spi_slave_rx_if #(.DATA_W(16)) rx_if ();

  spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs     (spi_cs),
    .spi_sclk   (spi_sclk),
    .spi_data   (spi_data),
    .rx         (rx_if),
    .fifo_level (fifo_level),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int ovr_cnt  = 0;
  int ferr_cnt = 0;

  // Observer only: records what the consumer side sees, never decides expectations.
  always @(negedge clk) begin
    if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
    if (overrun)   ovr_cnt++;
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shifts the top nbits of w, MSB first. With pop_on_last, rx_ready is raised
  // for exactly the cycle in which the final word lands in the FIFO.
  task automatic send_bits(input logic [15:0] w, input int nbits, input bit pop_on_last);
    for (int i = 0; i < nbits; i++) begin
      spi_data = w[15-i];
      clks(4);
      spi_sclk = 1'b1;
      if (pop_on_last && i == nbits - 1) begin
        clks(3);
        rx_if.rx_ready = 1'b1;
        clks(1);
        rx_if.rx_ready = 1'b0;
      end else begin
        clks(4);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    clks(4);
  endtask

  task automatic cs_high();
    clks(4);
    spi_cs = 1'b1;
    clks(8);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0;
    rx_if.rx_ready = 1'b0;
    clks(3);
    reset = 1'b0;
    clks(4);
    total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_if.rx_valid); end
    total++; if (rx_if.rx_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", rx_if.rx_data); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_word();
    int o0, f0;
    got_q.delete();
    o0 = ovr_cnt; f0 = ferr_cnt;
    rx_if.rx_ready = 1'b1;
    cs_low();
    send_bits(16'hA5C3, 16, 1'b0);
    cs_high();
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 16'hA5C3) begin bad++; $display("FAIL single_data: got %h want a5c3", got_q[0]); end
    end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL single_frame_err: got %0d want 0", ferr_cnt - f0); end
    total++; if (ovr_cnt - o0 !== 0) begin bad++; $display("FAIL single_overrun: got %0d want 0", ovr_cnt - o0); end
    rx_if.rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'h1234; words[1] = 16'hFFFF; words[2] = 16'h0001;
    got_q.delete();
    rx_if.rx_ready = 1'b0;
    cs_low();
    for (int k = 0; k < 3; k++) begin
      send_bits(words[k], 16, 1'b0);
      clks(2);
      total++; if (fifo_level !== 3'(k + 1)) begin bad++; $display("FAIL b2b_level%0d: got %0d want %0d", k, fifo_level, k + 1); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
    cs_high();
    rx_if.rx_ready = 1'b1;
    clks(8);
    rx_if.rx_ready = 1'b0;
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL b2b_drained: got %0d want 0", fifo_level); end
    total++; if (got_q.size() !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
    else for (int k = 0; k < 3; k++) begin
      total++; if (got_q[k] !== words[k]) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", k, got_q[k], words[k]); end
    end
  endtask

  // Five words into a four-deep FIFO with no consumer: the model keeps the
  // first four and expects exactly one overrun for the fifth.
  task automatic test_overflow();
    int o0, occ, exp_ovr;
    logic [15:0] w;
    got_q.delete(); exp_q.delete();
    o0 = ovr_cnt; occ = 0; exp_ovr = 0;
    rx_if.rx_ready = 1'b0;
    cs_low();
    for (int k = 0; k < 5; k++) begin
      w = 16'($urandom);
      send_bits(w, 16, 1'b0);
      if (occ < 4) begin exp_q.push_back(w); occ++; end
      else exp_ovr++;
    end
    cs_high();
    total++; if (ovr_cnt - o0 !== exp_ovr) begin bad++; $display("FAIL ovf_overrun: got %0d want %0d", ovr_cnt - o0, exp_ovr); end
    total++; if (fifo_level !== 3'(occ)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, occ); end
    rx_if.rx_ready = 1'b1;
    clks(10);
    rx_if.rx_ready = 1'b0;
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL ovf_word%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_full_pop();
    int o0;
    logic [15:0] w;
    got_q.delete(); exp_q.delete();
    o0 = ovr_cnt;
    rx_if.rx_ready = 1'b0;
    cs_low();
    for (int k = 0; k < 5; k++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      send_bits(w, 16, k == 4);
    end
    clks(1);
    total++; if (ovr_cnt - o0 !== 0) begin bad++; $display("FAIL fullpop_overrun: got %0d want 0", ovr_cnt - o0); end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fullpop_level: got %0d want 4", fifo_level); end
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL fullpop_popped: got %0d want 1", got_q.size()); end
    cs_high();
    rx_if.rx_ready = 1'b1;
    clks(10);
    rx_if.rx_ready = 1'b0;
    total++; if (got_q.size() !== 5) begin bad++; $display("FAIL fullpop_count: got %0d want 5", got_q.size()); end
    else foreach (exp_q[k]) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL fullpop_word%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_truncated();
    int f0;
    got_q.delete();
    f0 = ferr_cnt;
    rx_if.rx_ready = 1'b1;
    cs_low();
    send_bits(16'($urandom), 9, 1'b0);
    cs_high();
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL trunc_frame_err: got %0d want 1", ferr_cnt - f0); end
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL trunc_no_push: got %0d want 0", got_q.size()); end
    cs_low();
    send_bits(16'h00FF, 16, 1'b0);
    cs_high();
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL trunc_next_count: got %0d want 1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 16'h00FF) begin bad++; $display("FAIL trunc_next_data: got %h want 00ff", got_q[0]); end
    end
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL trunc_next_frame_err: got %0d want 1", ferr_cnt - f0); end
    rx_if.rx_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int f0;
    logic [15:0] w;
    w = 16'($urandom);
    rx_if.rx_ready = 1'b0;
    cs_low();
    send_bits(w, 7, 1'b0);
    got_q.delete();
    f0 = ferr_cnt;
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    rx_if.rx_ready = 1'b1;
    send_bits(w << 7, 9, 1'b0);
    clks(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    cs_high();
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL rstmid_frame_err: got %0d want 0", ferr_cnt - f0); end
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL rstmid_no_push: got %0d want 0", got_q.size()); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
    cs_low();
    send_bits(16'hBEEF, 16, 1'b0);
    cs_high();
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL rstmid_next_count: got %0d want 1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 16'hBEEF) begin bad++; $display("FAIL rstmid_next_data: got %h want beef", got_q[0]); end
    end
    rx_if.rx_ready = 1'b0;
  endtask

  // Random frames of 1-3 words with a randomly stalling consumer; the SPI
  // rate is far below the drain rate, so every word must arrive in order.
  task automatic test_random_frames();
    int o0, f0;
    bit done;
    logic [15:0] w;
    got_q.delete(); exp_q.delete();
    o0 = ovr_cnt; f0 = ferr_cnt; done = 1'b0;
    fork
      begin
        for (int f = 0; f < 4; f++) begin
          cs_low();
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            w = 16'($urandom);
            exp_q.push_back(w);
            send_bits(w, 16, 1'b0);
          end
          cs_high();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_if.rx_ready = 1'($urandom_range(0, 1));
          clks(1);
        end
      end
    join
    rx_if.rx_ready = 1'b1;
    clks(10);
    rx_if.rx_ready = 1'b0;
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand_word%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
    total++; if (ovr_cnt - o0 !== 0) begin bad++; $display("FAIL rand_overrun: got %0d want 0", ovr_cnt - o0); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL rand_frame_err: got %0d want 0", ferr_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_truncated();
    test_reset_midframe();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
